// File: rtl/ofm_axi_wr_master_if.sv
// Bundle of the job-control, result-stream and AXI4 write-channel signals
// seen by the output-feature-map write master.
interface ofm_axi_wr_master_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64
);
    // Job control
    logic                      ap_start;
    logic [ADDR_WIDTH-1:0]     dest_addr;
    logic [31:0]               words_num;
    logic                      ap_done;
    logic                      ap_idle;
    // Result stream from the accelerator core
    logic                      s_valid;
    logic                      s_ready;
    logic [DATA_WIDTH-1:0]     s_data;
    // AXI4 write address / data / response channels
    logic                      m_axi_awvalid;
    logic                      m_axi_awready;
    logic [ADDR_WIDTH-1:0]     m_axi_awaddr;
    logic [7:0]                m_axi_awlen;
    logic                      m_axi_wvalid;
    logic                      m_axi_wready;
    logic [DATA_WIDTH-1:0]     m_axi_wdata;
    logic [DATA_WIDTH/8-1:0]   m_axi_wstrb;
    logic                      m_axi_wlast;
    logic                      m_axi_bvalid;
    logic                      m_axi_bready;

    modport master (
        input  ap_start, dest_addr, words_num,
        input  s_valid, s_data,
        input  m_axi_awready, m_axi_wready, m_axi_bvalid,
        output ap_done, ap_idle, s_ready,
        output m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
        output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        output m_axi_bready
    );

    modport slave (
        output ap_start, dest_addr, words_num,
        output s_valid, s_data,
        output m_axi_awready, m_axi_wready, m_axi_bvalid,
        input  ap_done, ap_idle, s_ready,
        input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
        input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        input  m_axi_bready
    );
endinterface

// File: rtl/ofm_axi_wr_master.sv
// Output-feature-map AXI4 write master: drains the 512-bit result stream into
// host memory as INCR bursts of up to MAX_BURST beats, never crossing a 4 KB
// page, with a single burst in flight at a time.
module ofm_axi_wr_master #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    ofm_axi_wr_master_if.master     bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [31:0]            rem_q, rem_d;
    logic [6:0]             len_q, len_d;
    logic [6:0]             beat_q, beat_d;
    logic [6:0]             len_lim;
    logic [6:0]             page_room;
    logic                   in_aw;
    logic                   in_w;
    logic                   last_beat;

    // Burst length: smallest of the burst cap, the remaining words and the beats left in the 4 KB page
    always_comb begin
        page_room = 7'd64 - {1'b0, addr_q[11:6]};
        len_lim   = 7'(MAX_BURST);
        if ({1'b0, rem_q} < 33'(len_lim)) begin
            len_lim = rem_q[6:0];
        end
        if (page_room < len_lim) begin
            len_lim = page_room;
        end
    end

    // State, address, remaining-count and beat-counter registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
        end
    end

    assign last_beat = (beat_q == (len_q - 7'd1));

    // Next-state logic: start latching, burst sizing, handshake tracking and address advance
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        len_d   = len_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ap_start) begin
                    // Host address is forced onto a 64-byte word boundary
                    addr_d  = bus.dest_addr & ~ADDR_WIDTH'(63);
                    rem_d   = bus.words_num;
                    beat_d  = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (rem_q == 32'd0) begin
                    state_d = S_DONE;
                end else begin
                    len_d   = len_lim;
                    beat_d  = '0;
                    state_d = S_AW;
                end
            end
            S_AW: begin
                if (bus.m_axi_awready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                if (bus.s_valid && bus.m_axi_wready) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = S_B;
                    end else begin
                        beat_d  = beat_q + 7'd1;
                    end
                end
            end
            S_B: begin
                if (bus.m_axi_bvalid) begin
                    addr_d  = addr_q + ADDR_WIDTH'({len_q, 6'b0});
                    rem_d   = rem_q - 32'(len_q);
                    state_d = (rem_q == 32'(len_q)) ? S_DONE : S_CALC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_aw = (state_q == S_AW);
    assign in_w  = (state_q == S_W);

    // Outputs decode straight from the state register so a reset clears them without waiting for a clock
    assign bus.ap_idle       = (state_q == S_IDLE);
    assign bus.ap_done       = (state_q == S_DONE);
    assign bus.m_axi_awvalid = in_aw;
    assign bus.m_axi_awaddr  = in_aw ? addr_q : '0;
    assign bus.m_axi_awlen   = in_aw ? {1'b0, len_q - 7'd1} : 8'd0;
    // W channel is a zero-latency pass-through of the result stream while a burst is open
    assign bus.m_axi_wvalid  = in_w & bus.s_valid;
    assign bus.s_ready       = in_w & bus.m_axi_wready;
    assign bus.m_axi_wdata   = in_w ? bus.s_data : '0;
    assign bus.m_axi_wstrb   = in_w ? '1 : '0;
    assign bus.m_axi_wlast   = in_w & last_beat;
    assign bus.m_axi_bready  = (state_q == S_B);

endmodule
